// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one data memory between two requesters.
// Supports bounded locked bursts, out-of-range error pulses and registered read return.
module dmem_arbiter #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic        p0_lock,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic        p1_lock,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t        state, state_nxt;
    logic          rr_ptr, rr_nxt;
    logic          owner, owner_nxt;
    logic [CW-1:0] burst_cnt, burst_nxt, held_cnt;
    logic          win, xfer;
    logic          sel_we, sel_lock, in_range;
    logic [31:0]   sel_addr, sel_wdata;

    // Lone requester wins via ~p0_req; the value is irrelevant when nobody requests.
    always_comb begin
        if (state == LOCKED && (owner ? p1_req : p0_req)) win = owner;
        else if (p0_req && p1_req)                           win = rr_ptr;
        else                                                 win = ~p0_req;
    end

    assign xfer   = (p0_req | p1_req) & rst_n;
    assign p0_gnt = xfer & ~win;
    assign p1_gnt = xfer & win;

    assign sel_we    = win ? p1_we    : p0_we;
    assign sel_lock  = win ? p1_lock  : p0_lock;
    assign sel_addr  = win ? p1_addr  : p0_addr;
    assign sel_wdata = win ? p1_wdata : p0_wdata;
    assign in_range  = sel_addr < DEPTH;

    assign mem_read  = xfer & ~sel_we & in_range;
    assign mem_write = xfer & sel_we & in_range;
    assign mem_raddr = mem_read  ? sel_addr  : '0;
    assign mem_waddr = mem_write ? sel_addr  : '0;
    assign mem_wdata = mem_write ? sel_wdata : '0;

    // A new winner (including a takeover after the owner drops req) starts its burst count from zero.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        burst_nxt = burst_cnt;
        held_cnt  = (state == LOCKED && win == owner) ? burst_cnt : '0;
        if (xfer) begin
            if (sel_lock && held_cnt < CW'(MAX_BURST - 1)) begin
                state_nxt = LOCKED;
                owner_nxt = win;
                burst_nxt = held_cnt + 1'b1;
            end else begin
                state_nxt = ARB;
                burst_nxt = '0;
                rr_nxt    = ~win;
            end
        end else if (state == LOCKED) begin
            state_nxt = ARB;
            burst_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB;
            rr_ptr    <= 1'b0;
            owner     <= 1'b0;
            burst_cnt <= '0;
            p0_rvalid <= 1'b0;
            p0_err    <= 1'b0;
            p0_rdata  <= '0;
            p1_rvalid <= 1'b0;
            p1_err    <= 1'b0;
            p1_rdata  <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_nxt;
            p0_rvalid <= p0_gnt & ~sel_we;
            p0_err    <= p0_gnt & ~in_range;
            p1_rvalid <= p1_gnt & ~sel_we;
            p1_err    <= p1_gnt & ~in_range;
            if (p0_gnt && !sel_we) p0_rdata <= in_range ? mem_rdata : '0;
            if (p1_gnt && !sel_we) p1_rdata <= in_range ? mem_rdata : '0;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model with a shadow copy of memory.
module tb_dmem_arbiter;
    localparam int DEPTH     = 256;
    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic        mem_loaded = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    int          m_owner, m_cnt, m_pref;
    logic        e_rv [2];
    logic        e_err [2];
    logic [31:0] e_rd [2];

    dmem_arbiter #(.DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: combinational read while strobed, write commits at the edge.
    assign mem_rdata = mem_read ? mem[mem_raddr[7:0]] : 32'hBAD0BAD0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA5000000 + 32'(i);
            mem_loaded <= 1'b1;
        end else if (mem_write) begin
            mem[mem_waddr[7:0]] <= mem_wdata;
        end
    end

    task automatic idle_all();
        p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic drive(input int p, input logic we, input logic lock,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            p0_req = 1; p0_we = we; p0_lock = lock; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = 1; p1_we = we; p1_lock = lock; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_all();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        m_owner = -1; m_cnt = 0; m_pref = 0;
        for (int k = 0; k < 2; k++) begin e_rv[k] = 0; e_err[k] = 0; e_rd[k] = '0; end
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_all();
        drive(0, 0, 0, 32'd3, '0);
        drive(1, 1, 0, 32'd4, 32'h11);
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if ({p0_gnt, p1_gnt, mem_read, mem_write} !== 4'b0) begin n_fail++; $display("FAIL rst_strobes: got %b want 0000", {p0_gnt, p1_gnt, mem_read, mem_write}); end
        n_checks++; if ({p0_rvalid, p0_err, p1_rvalid, p1_err} !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {p0_rvalid, p0_err, p1_rvalid, p1_err}); end
        n_checks++; if ({p0_rdata, p1_rdata} !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", {p0_rdata, p1_rdata}); end
        n_checks++; if ({mem_raddr, mem_waddr, mem_wdata} !== 96'h0) begin n_fail++; $display("FAIL rst_membus: got %h want 0", {mem_raddr, mem_waddr, mem_wdata}); end
        idle_all();
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        drive(0, 0, 0, 32'd5, '0);
        #1;
        n_checks++; if ({p0_gnt, mem_read} !== 2'b11) begin n_fail++; $display("FAIL midrd_gnt: got %b want 11", {p0_gnt, mem_read}); end
        n_checks++; if (mem_raddr !== 32'd5) begin n_fail++; $display("FAIL midrd_raddr: got %h want 5", mem_raddr); end
        #1 rst_n = 0;
        #1;
        n_checks++; if ({p0_gnt, mem_read} !== 2'b00) begin n_fail++; $display("FAIL midrd_gnt_in_rst: got %b want 00", {p0_gnt, mem_read}); end
        @(negedge clk);
        n_checks++; if ({p0_rvalid, p0_rdata} !== 33'h0) begin n_fail++; $display("FAIL midrd_discard: got %b/%h want 0/0", p0_rvalid, p0_rdata); end
        idle_all();
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        n_checks++; if (p0_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrd_after: got %b want 0", p0_rvalid); end
    endtask

    task automatic test_single();
        @(negedge clk);
        idle_all();
        drive(0, 1, 0, 32'd10, 32'hDEADBEEF);
        #1;
        n_checks++; if ({p0_gnt, p1_gnt, mem_write, mem_read} !== 4'b1010) begin n_fail++; $display("FAIL single_wr_strobes: got %b want 1010", {p0_gnt, p1_gnt, mem_write, mem_read}); end
        n_checks++; if ({mem_waddr, mem_wdata, mem_raddr} !== {32'd10, 32'hDEADBEEF, 32'd0}) begin n_fail++; $display("FAIL single_wr_bus: got %h want 0000000a deadbeef 0", {mem_waddr, mem_wdata, mem_raddr}); end
        ref_mem[10] = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++; if ({p0_rvalid, p0_err} !== 2'b00) begin n_fail++; $display("FAIL single_wr_resp: got %b want 00", {p0_rvalid, p0_err}); end
        idle_all();
        drive(0, 0, 0, 32'd10, '0);
        #1;
        n_checks++; if ({p0_gnt, mem_read, mem_write, mem_raddr, mem_wdata} !== {3'b110, 32'd10, 32'd0}) begin n_fail++; $display("FAIL single_rd_bus: got %b %h want 110 0000000a", {p0_gnt, mem_read, mem_write}, mem_raddr); end
        @(negedge clk);
        idle_all();
        n_checks++; if ({p0_rvalid, p0_err, p0_rdata} !== {2'b10, 32'hDEADBEEF}) begin n_fail++; $display("FAIL single_rd_data: got %b %h want 10 deadbeef", {p0_rvalid, p0_err}, p0_rdata); end
        @(negedge clk);
        n_checks++; if ({p0_rvalid, p0_rdata} !== {1'b0, 32'hDEADBEEF}) begin n_fail++; $display("FAIL single_rd_hold: got %b %h want 0 deadbeef", p0_rvalid, p0_rdata); end
    endtask

    task automatic test_contention();
        int prev;
        logic [31:0] want;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                prev = (i - 1) % 2;
                want = (prev == 0) ? ref_mem[20] : ref_mem[40];
                n_checks++; if ({p0_rvalid, p1_rvalid} !== {prev == 0, prev == 1}) begin n_fail++; $display("FAIL cont_rvalid[%0d]: got %b want port %0d", i, {p0_rvalid, p1_rvalid}, prev); end
                n_checks++; if (((prev == 0) ? p0_rdata : p1_rdata) !== want) begin n_fail++; $display("FAIL cont_rdata[%0d]: got %h want %h", i, (prev == 0) ? p0_rdata : p1_rdata, want); end
            end
            drive(0, 0, 0, 32'd20, '0);
            drive(1, 0, 0, 32'd40, '0);
            #1;
            n_checks++; if ({p0_gnt, p1_gnt} !== {(i % 2) == 0, (i % 2) == 1}) begin n_fail++; $display("FAIL cont_gnt[%0d]: got %b want %b", i, {p0_gnt, p1_gnt}, {(i % 2) == 0, (i % 2) == 1}); end
        end
        @(negedge clk);
        idle_all();
        n_checks++; if ({p0_rvalid, p1_rvalid, p1_rdata} !== {2'b01, ref_mem[40]}) begin n_fail++; $display("FAIL cont_last: got %b %h want 01 %h", {p0_rvalid, p1_rvalid}, p1_rdata, ref_mem[40]); end
    endtask

    task automatic test_lock_burst();
        logic [5:0] exp_p1;
        exp_p1 = 6'b101111;
        do_reset();
        @(negedge clk);
        drive(0, 0, 0, 32'd1, '0);
        #1;
        n_checks++; if (p0_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_prime: got %b want 1", p0_gnt); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 32'd2, '0);
            drive(1, 0, 1, 32'd3, '0);
            #1;
            n_checks++; if ({p0_gnt, p1_gnt} !== {~exp_p1[i], exp_p1[i]}) begin n_fail++; $display("FAIL lock_gnt[%0d]: got %b want %b", i, {p0_gnt, p1_gnt}, {~exp_p1[i], exp_p1[i]}); end
        end
        @(negedge clk);
        idle_all();
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        idle_all();
        @(negedge clk);
        drive(1, 1, 0, 32'd256, 32'h12345678);
        #1;
        n_checks++; if ({p1_gnt, p0_gnt, mem_write, mem_read} !== 4'b1000) begin n_fail++; $display("FAIL oor_wr_strobes: got %b want 1000", {p1_gnt, p0_gnt, mem_write, mem_read}); end
        n_checks++; if ({mem_waddr, mem_wdata} !== 64'h0) begin n_fail++; $display("FAIL oor_wr_bus: got %h want 0", {mem_waddr, mem_wdata}); end
        @(negedge clk);
        n_checks++; if ({p1_err, p1_rvalid} !== 2'b10) begin n_fail++; $display("FAIL oor_wr_err: got %b want 10", {p1_err, p1_rvalid}); end
        idle_all();
        drive(1, 0, 0, 32'd300, '0);
        #1;
        n_checks++; if ({p1_gnt, mem_read, mem_raddr} !== {2'b10, 32'd0}) begin n_fail++; $display("FAIL oor_rd_strobes: got %b %h want 10 0", {p1_gnt, mem_read}, mem_raddr); end
        @(negedge clk);
        idle_all();
        n_checks++; if ({p1_err, p1_rvalid, p1_rdata, p0_err} !== {2'b11, 32'd0, 1'b0}) begin n_fail++; $display("FAIL oor_rd_resp: got %b %h want 11 0", {p1_err, p1_rvalid}, p1_rdata); end
        @(negedge clk);
        n_checks++; if ({p1_err, p1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL oor_pulse_end: got %b want 00", {p1_err, p1_rvalid}); end
        n_checks++; if ({mem[0], mem[44]} !== {ref_mem[0], ref_mem[44]}) begin n_fail++; $display("FAIL oor_mem_untouched: got %h %h want %h %h", mem[0], mem[44], ref_mem[0], ref_mem[44]); end
    endtask

    task automatic test_random();
        logic        req [2];
        logic        we [2];
        logic        lock [2];
        logic [31:0] addr [2];
        logic [31:0] wdata [2];
        int          w, wi, held;
        logic        ok, erd, ewr;
        logic [31:0] eraddr, ewaddr, ewdata;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            n_checks++; if ({p0_rvalid, p1_rvalid, p0_err, p1_err} !== {e_rv[0], e_rv[1], e_err[0], e_err[1]}) begin n_fail++; $display("FAIL rnd_flags[%0d]: got %b want %b", c, {p0_rvalid, p1_rvalid, p0_err, p1_err}, {e_rv[0], e_rv[1], e_err[0], e_err[1]}); end
            n_checks++; if ({p0_rdata, p1_rdata} !== {e_rd[0], e_rd[1]}) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h %h want %h %h", c, p0_rdata, p1_rdata, e_rd[0], e_rd[1]); end
            n_checks++; if (p0_rvalid && p1_rvalid) begin n_fail++; $display("FAIL rnd_dual_rvalid[%0d]: got 11 want not both", c); end
            for (int k = 0; k < 2; k++) begin
                req[k]   = ($urandom_range(0, 9) < 7);
                we[k]    = $urandom_range(0, 1) == 1;
                lock[k]  = $urandom_range(0, 1) == 1;
                addr[k]  = ($urandom_range(0, 11) == 0) ? 32'($urandom_range(256, 4095)) : 32'($urandom_range(0, 255));
                wdata[k] = $urandom;
            end
            p0_req = req[0]; p0_we = we[0]; p0_lock = lock[0]; p0_addr = addr[0]; p0_wdata = wdata[0];
            p1_req = req[1]; p1_we = we[1]; p1_lock = lock[1]; p1_addr = addr[1]; p1_wdata = wdata[1];
            #1;
            if (m_owner >= 0 && req[m_owner]) w = m_owner;
            else if (req[0] && req[1])          w = m_pref;
            else if (req[0])                    w = 0;
            else if (req[1])                    w = 1;
            else                                w = -1;
            wi  = (w < 0) ? 0 : w;
            ok  = (w >= 0) && (addr[wi] < DEPTH);
            erd = ok && !we[wi];
            ewr = ok && we[wi];
            eraddr = erd ? addr[wi] : '0;
            ewaddr = ewr ? addr[wi] : '0;
            ewdata = ewr ? wdata[wi] : '0;
            n_checks++; if ({p0_gnt, p1_gnt, mem_read, mem_write} !== {w == 0, w == 1, erd, ewr}) begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %b want %b", c, {p0_gnt, p1_gnt, mem_read, mem_write}, {w == 0, w == 1, erd, ewr}); end
            n_checks++; if ({mem_raddr, mem_waddr, mem_wdata} !== {eraddr, ewaddr, ewdata}) begin n_fail++; $display("FAIL rnd_bus[%0d]: got %h %h %h want %h %h %h", c, mem_raddr, mem_waddr, mem_wdata, eraddr, ewaddr, ewdata); end
            for (int k = 0; k < 2; k++) begin
                e_rv[k]  = (w == k) && !we[k];
                e_err[k] = (w == k) && !(addr[k] < DEPTH);
                if (e_rv[k]) e_rd[k] = (addr[k] < DEPTH) ? ref_mem[addr[k][7:0]] : '0;
            end
            if (ewr) ref_mem[addr[wi][7:0]] = wdata[wi];
            if (w < 0) begin
                m_owner = -1; m_cnt = 0;
            end else begin
                held = (w == m_owner) ? m_cnt : 0;
                if (lock[wi] && held < MAX_BURST - 1) begin
                    m_owner = w; m_cnt = held + 1;
                end else begin
                    m_owner = -1; m_cnt = 0; m_pref = 1 - w;
                end
            end
        end
        @(negedge clk);
        idle_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA5000000 + 32'(i);
        m_owner = -1; m_cnt = 0; m_pref = 0;
        test_reset();
        test_single();
        test_contention();
        test_lock_burst();
        test_out_of_range();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single data memory between requester 0 (CPU load/store stage) and requester 1 (DMA/debug loader).
- Drives the memory's read/write strobes, addresses and write data.
- Registers read data back to the winning requester.
- Round-robin arbitration, with an optional bounded locked burst per requester.

Parameters:
- DEPTH, 256: number of valid 32-bit words in data memory. Word index is addr[7:0]. Addresses >= DEPTH are out of range.
- MAX_BURST, 4: maximum consecutive handshakes one locked owner may hold (>=1).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- p0_req  in  1  requester 0 access request
- p0_we  in  1  1 = write, 0 = read
- p0_lock  in  1  request to keep ownership for next access
- p0_addr  in  32  word address
- p0_wdata  in  32  write data
- p0_gnt  out  1  handshake accepted this cycle (combinational)
- p0_rvalid  out  1  read data valid (registered)
- p0_rdata  out  32  read data
- p0_err  out  1  out-of-range access pulse (registered)
- p1_req, p1_we, p1_lock, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: identical set for requester 1
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_raddr  out  32  memory read address
- mem_waddr  out  32  memory write address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data; combinational, valid only while mem_read=1

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=ARB, rr_ptr=0 (requester 0 preferred), owner=0, burst_cnt=0.
  - All rvalid/err/rdata outputs = 0.
  - Any in-flight read response is discarded.
  - gnt, mem_read and mem_write are 0 while rst_n=0.
- State ARB, winner selection (combinational):
  - Only one requesting: that one wins.
  - Both requesting: the requester at rr_ptr wins.
- State LOCKED: the owner wins if its req=1. Otherwise winner selection is as in ARB, in the same cycle (no bubble).
- Handshake:
  - gnt=1 only for the winner, and only when its req=1.
  - A transfer occurs in a cycle where req&&gnt.
  - At most one gnt per cycle.
- Memory drive during a transfer:
  - Read: mem_read=1 and mem_raddr=addr.
  - Write: mem_write=1, mem_waddr=addr, mem_wdata=wdata.
  - Write commits at the same edge, inside the memory.
  - Unused address/data outputs = 0. Strobes = 0 when idle.
- Out-of-range access (addr >= DEPTH):
  - No memory strobe is issued, so the write is dropped.
  - The handshake still completes. Next cycle: err=1 for one cycle.
  - If the access was a read, rvalid=1 also pulses and rdata=0.
- Read latency:
  - mem_rdata is captured at the handshake edge.
  - The requester's rvalid=1 and rdata=data appear the following cycle, for exactly one cycle.
  - Back-to-back reads give rvalid every cycle.
  - rdata holds its last value when rvalid=0.
- Round robin: after every handshake that does not continue a lock, rr_ptr = other requester.
- Lock/burst:
  - A handshake with lock=1 and burst_cnt < MAX_BURST-1 moves to LOCKED(owner=winner) and increments burst_cnt.
  - A handshake with lock=0, or with burst_cnt = MAX_BURST-1, does the following:
    - state=ARB, burst_cnt=0;
    - rr_ptr = other requester, so the other side gets the next contested cycle;
    - the owner loses priority.
  - The owner dropping req while LOCKED: state=ARB, burst_cnt=0, rr_ptr unchanged.
- Simultaneous events:
  - A response for one port and a handshake for the other in the same cycle are independent.
  - Both ports may never receive rvalid in the same cycle.

Test Plan:
- Reset mid-read: p0 read at addr 5 handshakes, rst_n pulled low before the next edge -> p0_rvalid stays 0; all outputs 0 and strobes low while reset is held.
- Single requester: p0 writes 0xDEADBEEF to addr 10, then reads addr 10 -> one-cycle gnt each time; next cycle p0_rvalid=1, p0_rdata=0xDEADBEEF.
- Contention: p0 and p1 both hold read requests for 4 cycles -> grants alternate p0,p1,p0,p1; each rvalid is on the correct port one cycle later.
- Locked burst, MAX_BURST=4: p1 holds req+lock for 6 cycles while p0 requests -> p1 granted 4 consecutive, then p0 granted, then p1.
- Out-of-range: p1 writes addr 256, then reads addr 300 -> no mem_write/mem_read strobe; p1_err pulses twice; second pulse comes with p1_rvalid=1 and p1_rdata=0; memory contents unchanged.
